display_mux_scheduler: RTL

- Owns the 4-digit seven-segment display and shares it among three requesters: a timed alert source (lives/score popups), the game arrow lane, and an idle/menu source.
- Scans the four digits at a fixed refresh rate and latches the winning source only at frame boundaries, so a frame never mixes sources.
- Encodes 5-bit glyph codes to active-low segment patterns using the shared SEG_* constants from the DDR definitions file.
- Sits between the game FSM / lives logic and the board seg/an pins.

---
 rtl/display_mux_scheduler.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/display_mux_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | display_mux_scheduler                                                    |
// | Shares the 4-digit seven-segment display between alert, game and idle    |
// | sources; the winner is switched only at frame boundaries.                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module display_mux_scheduler #(
   parameter int SCAN_DIV   = 100000,
   parameter int HOLD_BEATS = 4,
   parameter int CODE_BITS  = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   metronome_clk,
   input  logic                   game_en,
   input  logic [4*CODE_BITS-1:0] game_digits,
   input  logic                   alert_req,
   input  logic [4*CODE_BITS-1:0] alert_digits,
   input  logic [4*CODE_BITS-1:0] idle_digits,
   output logic                   alert_busy,
   output logic [1:0]             grant,
   output logic [6:0]             seg,
   output logic [3:0]             an
);

   localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int HOLD_W = $clog2(HOLD_BEATS + 1);

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_BEATS);
   localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

   // Active-low segment patterns, bit order {g,f,e,d,c,b,a}; these mirror
   // the shared SEG_* glyph constants of the DDR definitions.
   localparam logic [6:0] SEG_ZERO             = 7'b1000000;
   localparam logic [6:0] SEG_ONE              = 7'b1111001;
   localparam logic [6:0] SEG_TWO              = 7'b0100100;
   localparam logic [6:0] SEG_THREE            = 7'b0110000;
   localparam logic [6:0] SEG_FOUR             = 7'b0011001;
   localparam logic [6:0] SEG_FIVE             = 7'b0010010;
   localparam logic [6:0] SEG_SIX              = 7'b0000010;
   localparam logic [6:0] SEG_SEVEN            = 7'b1111000;
   localparam logic [6:0] SEG_EIGHT            = 7'b0000000;
   localparam logic [6:0] SEG_NINE             = 7'b0010000;
   localparam logic [6:0] SEG_ARROW_UP         = 7'b1011100;
   localparam logic [6:0] SEG_ARROW_DOWN       = 7'b1100011;
   localparam logic [6:0] SEG_ARROW_LEFT       = 7'b1001110;
   localparam logic [6:0] SEG_ARROW_RIGHT      = 7'b1110100;
   localparam logic [6:0] SEG_ARROW_UP_DOWN    = 7'b1110110;
   localparam logic [6:0] SEG_ARROW_UP_LEFT    = 7'b1011110;
   localparam logic [6:0] SEG_ARROW_UP_RIGHT   = 7'b1111100;
   localparam logic [6:0] SEG_ARROW_DOWN_LEFT  = 7'b1001111;
   localparam logic [6:0] SEG_ARROW_DOWN_RIGHT = 7'b1100111;
   localparam logic [6:0] SEG_ARROW_LEFT_RIGHT = 7'b0111111;
   localparam logic [6:0] SEG_ARROW_NONE       = 7'b0110110;
   localparam logic [6:0] SEG_BLANK            = 7'b1111111;

   typedef enum logic [1:0] {
      GRANT_IDLE  = 2'd0,
      GRANT_GAME  = 2'd1,
      GRANT_ALERT = 2'd2
   } grant_t;

   function automatic logic [6:0] encode(input logic [CODE_BITS-1:0] code);
      logic [6:0] pattern;
      case (code)
         5'd0:    pattern = SEG_ZERO;
         5'd1:    pattern = SEG_ONE;
         5'd2:    pattern = SEG_TWO;
         5'd3:    pattern = SEG_THREE;
         5'd4:    pattern = SEG_FOUR;
         5'd5:    pattern = SEG_FIVE;
         5'd6:    pattern = SEG_SIX;
         5'd7:    pattern = SEG_SEVEN;
         5'd8:    pattern = SEG_EIGHT;
         5'd9:    pattern = SEG_NINE;
         5'd10:   pattern = SEG_ARROW_UP;
         5'd11:   pattern = SEG_ARROW_DOWN;
         5'd12:   pattern = SEG_ARROW_LEFT;
         5'd13:   pattern = SEG_ARROW_RIGHT;
         5'd14:   pattern = SEG_ARROW_UP_DOWN;
         5'd15:   pattern = SEG_ARROW_UP_LEFT;
         5'd16:   pattern = SEG_ARROW_UP_RIGHT;
         5'd17:   pattern = SEG_ARROW_DOWN_LEFT;
         5'd18:   pattern = SEG_ARROW_DOWN_RIGHT;
         5'd19:   pattern = SEG_ARROW_LEFT_RIGHT;
         5'd20:   pattern = SEG_ARROW_NONE;
         default: pattern = SEG_BLANK;
      endcase
      return pattern;
   endfunction

   // Metronome synchronizer and history
   logic s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
   logic beat;

   // Alert hold
   logic [4*CODE_BITS-1:0] alert_buf_q, alert_buf_d;
   logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
   logic                   alert_busy_q, alert_busy_d;

   // Scan and frame
   logic [DIV_W-1:0]            div_q, div_d;
   logic [1:0]                  scan_idx_q, scan_idx_d;
   logic [3:0][CODE_BITS-1:0]   frame_q, frame_d;
   grant_t                      grant_q, grant_d;
   logic [6:0]                  seg_q, seg_d;
   logic [3:0]                  an_q, an_d;

   logic [4*CODE_BITS-1:0] win_digits;
   grant_t                 win_grant;
   logic                   div_last;
   logic                   frame_end;

   always_comb begin
      s1_d = metronome_clk;
      s2_d = s1_q;
      s3_d = s2_q;
      beat = s2_q & ~s3_q;
   end

   // A new request always wins over a simultaneous beat and restarts the hold.
   always_comb begin
      alert_buf_d  = alert_buf_q;
      hold_cnt_d   = hold_cnt_q;
      alert_busy_d = alert_busy_q;
      if (alert_req) begin
         alert_buf_d  = alert_digits;
         hold_cnt_d   = HOLD_LOAD;
         alert_busy_d = 1'b1;
      end else if (beat && alert_busy_q) begin
         hold_cnt_d = hold_cnt_q - HOLD_ONE;
         if (hold_cnt_q == HOLD_ONE) begin
            alert_busy_d = 1'b0;
         end
      end
   end

   always_comb begin
      win_digits = idle_digits;
      win_grant  = GRANT_IDLE;
      if (alert_busy_q) begin
         win_digits = alert_buf_q;
         win_grant  = GRANT_ALERT;
      end else if (game_en) begin
         win_digits = game_digits;
         win_grant  = GRANT_GAME;
      end
   end

   always_comb begin
      div_last   = (div_q == DIV_LAST);
      frame_end  = div_last && (scan_idx_q == 2'd3);
      div_d      = div_last ? '0 : div_q + DIV_W'(1);
      scan_idx_d = div_last ? scan_idx_q + 2'd1 : scan_idx_q;
      frame_d    = frame_q;
      grant_d    = grant_q;
      if (frame_end) begin
         frame_d = win_digits;
         grant_d = win_grant;
      end
   end

   // Pin drivers lag scan_idx by one clock so they come straight off flops.
   always_comb begin
      an_d = 4'b1111;
      case (scan_idx_q)
         2'd0:    an_d = 4'b0111;
         2'd1:    an_d = 4'b1011;
         2'd2:    an_d = 4'b1101;
         default: an_d = 4'b1110;
      endcase
      seg_d = encode(frame_q[scan_idx_q]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q         <= 1'b0;
         s2_q         <= 1'b0;
         s3_q         <= 1'b0;
         alert_buf_q  <= '0;
         hold_cnt_q   <= '0;
         alert_busy_q <= 1'b0;
         div_q        <= '0;
         scan_idx_q   <= 2'd0;
         frame_q      <= '1;
         grant_q      <= GRANT_IDLE;
         seg_q        <= SEG_BLANK;
         an_q         <= 4'b1111;
      end else begin
         s1_q         <= s1_d;
         s2_q         <= s2_d;
         s3_q         <= s3_d;
         alert_buf_q  <= alert_buf_d;
         hold_cnt_q   <= hold_cnt_d;
         alert_busy_q <= alert_busy_d;
         div_q        <= div_d;
         scan_idx_q   <= scan_idx_d;
         frame_q      <= frame_d;
         grant_q      <= grant_d;
         seg_q        <= seg_d;
         an_q         <= an_d;
      end
   end

   assign alert_busy = alert_busy_q;
   assign grant      = grant_q;
   assign seg        = seg_q;
   assign an         = an_q;

endmodule
`default_nettype wire
